// File: rtl/e2lp_switch_input.sv
// E2LP slide-switch input: 2-FF synchronizer, tick-based debounce filter and sticky
// per-bit change flags cleared by Get. Define E2LP_SWITCH_IRQ_EN to add Irq_mask/Irq.
module e2lp_switch_input #(
    parameter int unsigned DIVIDER      = 50000,
    parameter int unsigned STABLE_COUNT = 4
) (
    input  logic       system_clock,
    input  logic       system_reset,
    input  logic [7:0] SWITCHES,
    input  logic       Get,
`ifdef E2LP_SWITCH_IRQ_EN
    input  logic [7:0] Irq_mask,
    output logic       Irq,
`endif
    output logic [7:0] o_Switches,
    output logic [7:0] o_Events,
    output logic       o_Changed
);

    localparam int unsigned NBITS = 8;
    localparam int unsigned PW    = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam int unsigned CW    = $clog2(STABLE_COUNT + 1);

    logic [NBITS-1:0]         sync_q1;
    logic [NBITS-1:0]         sync_q2;
    logic [PW-1:0]            presc_q;
    logic                     tick_c;
    logic [NBITS-1:0][CW-1:0] cnt_q;
    logic [NBITS-1:0][CW-1:0] cnt_d;
    logic [NBITS-1:0]         sw_d;
    logic [NBITS-1:0]         upd_c;
    logic [NBITS-1:0]         events_d;

    // Two-stage synchronizer for the asynchronous switch pins
    always_ff @(posedge system_clock or negedge system_reset) begin
        if (!system_reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= SWITCHES;
            sync_q2 <= sync_q1;
        end
    end

    // Free-running sample prescaler
    always_ff @(posedge system_clock or negedge system_reset) begin
        if (!system_reset) begin
            presc_q <= '0;
        end else if (presc_q == PW'(DIVIDER - 1)) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    assign tick_c = (presc_q == PW'(DIVIDER - 1));

    // Per-bit filter: any agreement restarts the count, a full run of ticks accepts
    always_comb begin
        cnt_d = cnt_q;
        sw_d  = o_Switches;
        upd_c = '0;
        for (int i = 0; i < NBITS; i++) begin
            if (sync_q2[i] == o_Switches[i]) begin
                cnt_d[i] = '0;
            end else if (tick_c) begin
                if (cnt_q[i] == CW'(STABLE_COUNT - 1)) begin
                    sw_d[i]  = sync_q2[i];
                    cnt_d[i] = '0;
                    upd_c[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        // A Get in the same cycle as an update cannot swallow the new event
        events_d = upd_c | (o_Events & ~{NBITS{Get}});
    end

    always_ff @(posedge system_clock or negedge system_reset) begin
        if (!system_reset) begin
            cnt_q      <= '0;
            o_Switches <= '0;
            o_Events   <= '0;
            o_Changed  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            o_Switches <= sw_d;
            o_Events   <= events_d;
            o_Changed  <= |events_d;
        end
    end

`ifdef E2LP_SWITCH_IRQ_EN
    // Level interrupt, coincident with the masked event flags
    always_ff @(posedge system_clock or negedge system_reset) begin
        if (!system_reset) begin
            Irq <= 1'b0;
        end else begin
            Irq <= |(events_d & Irq_mask);
        end
    end
`endif

endmodule

// File: tb/tb_e2lp_switch_input.sv
// Randomized bench for e2lp_switch_input against a per-cycle behavioural model,
// plus directed scenarios with hand-computed expectations (DIVIDER=4, STABLE_COUNT=3).
module tb_e2lp_switch_input;

    localparam int unsigned DIV = 4;
    localparam int unsigned SC  = 3;

    logic       clk;
    logic       rst_n = 1'b0;
    logic [7:0] SWITCHES = 8'h00;
    logic       Get = 1'b0;
    logic [7:0] irq_mask_v = 8'h00;
    logic [7:0] o_Switches;
    logic [7:0] o_Events;
    logic       o_Changed;
    logic       irq_w;

    int n_checks = 0;
    int n_fail   = 0;
    logic cmp_en = 1'b0;

    e2lp_switch_input #(.DIVIDER(DIV), .STABLE_COUNT(SC)) dut (
        .system_clock (clk),
        .system_reset (rst_n),
        .SWITCHES     (SWITCHES),
        .Get          (Get),
`ifdef E2LP_SWITCH_IRQ_EN
        .Irq_mask     (irq_mask_v),
        .Irq          (irq_w),
`endif
        .o_Switches   (o_Switches),
        .o_Events     (o_Events),
        .o_Changed    (o_Changed)
    );

`ifndef E2LP_SWITCH_IRQ_EN
    assign irq_w = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: pins are seen two clocks late, a level is accepted once it has
    // disagreed with the output continuously across SC sample ticks.
    typedef struct packed {
        logic [31:0]     cyc;
        logic [7:0]      s1;
        logic [7:0]      s2;
        logic [7:0]      sw;
        logic [7:0]      ev;
        logic            chg;
        logic            irq;
        logic [7:0][7:0] run;
    } model_t;

    model_t m;

    function automatic model_t model_step(model_t cur, logic [7:0] pins, logic get,
                                          logic [7:0] mask);
        model_t     nx = cur;
        logic [7:0] upd = '0;
        logic       tk;
        tk = (cur.cyc % DIV) == DIV - 1;
        nx.cyc = cur.cyc + 32'd1;
        for (int b = 0; b < 8; b++) begin
            if (cur.s2[b] == cur.sw[b]) begin
                nx.run[b] = 8'd0;
            end else if (tk) begin
                if (int'(cur.run[b]) + 1 == int'(SC)) begin
                    nx.sw[b]  = cur.s2[b];
                    nx.run[b] = 8'd0;
                    upd[b]    = 1'b1;
                end else begin
                    nx.run[b] = cur.run[b] + 8'd1;
                end
            end
        end
        nx.ev  = upd | (cur.ev & ~{8{get}});
        nx.chg = |nx.ev;
        nx.irq = |(nx.ev & mask);
        nx.s2  = cur.s1;
        nx.s1  = pins;
        return nx;
    endfunction

    function automatic logic will_upd(model_t cur, int b);
        return ((cur.cyc % DIV) == DIV - 1) && (cur.s2[b] != cur.sw[b]) &&
               (int'(cur.run[b]) + 1 == int'(SC));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= model_step(m, SWITCHES, Get, irq_mask_v);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model o_Switches", 32'(o_Switches), 32'(m.sw));
            chk("model o_Events", 32'(o_Events), 32'(m.ev));
            chk("model o_Changed", 32'(o_Changed), 32'(m.chg));
`ifdef E2LP_SWITCH_IRQ_EN
            chk("model Irq", 32'(irq_w), 32'(m.irq));
`endif
        end
    end

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits (bounded) for (o_Switches & msk) == val; returns the number of clocks taken
    task automatic wait_sw(input logic [7:0] msk, input logic [7:0] val, input int lim,
                           output int n);
        n = 0;
        while (((o_Switches & msk) != val) && n < lim) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pulse_get();
        Get = 1'b1;
        @(negedge clk);
        Get = 1'b0;
    endtask

    int n;
    int hold;

    initial begin
        // 1) reset, then quiet run
        clocks(2);
        cmp_en = 1'b1;
        chk("reset o_Switches", 32'(o_Switches), 32'h0);
        rst_n = 1'b1;
        clocks(100);
        chk("idle o_Switches", 32'(o_Switches), 32'h00);
        chk("idle o_Events", 32'(o_Events), 32'h00);
        chk("idle o_Changed", 32'(o_Changed), 32'h0);

        // 2) clean step on bit 0
        SWITCHES = 8'h01;
        wait_sw(8'h01, 8'h01, 40, n);
        chk("step accepted", 32'(o_Switches[0]), 32'h1);
        chk("step latency in 11..14", 32'(n >= 11 && n <= 14), 32'h1);
        chk("step o_Events", 32'(o_Events), 32'h01);
        chk("step o_Changed", 32'(o_Changed), 32'h1);

        // 3) 5-clock glitch on bit 3 must be rejected
        SWITCHES = 8'h09;
        clocks(5);
        SWITCHES = 8'h01;
        clocks(50);
        chk("glitch o_Switches", 32'(o_Switches), 32'h01);
        chk("glitch o_Events", 32'(o_Events), 32'h01);

        // 4) Get clears; Get coincident with an update keeps the new flag
        pulse_get();
        chk("get o_Events", 32'(o_Events), 32'h00);
        chk("get o_Changed", 32'(o_Changed), 32'h0);
        SWITCHES = 8'h03;
        n = 0;
        while (!will_upd(m, 1) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("upd cycle found", 32'(n < 40), 32'h1);
        pulse_get();
        chk("get+upd o_Events", 32'(o_Events), 32'h02);
        chk("get+upd o_Changed", 32'(o_Changed), 32'h1);
        pulse_get();

        // 5) reset mid-count
        SWITCHES = 8'hA5;
        clocks(6);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst o_Switches", 32'(o_Switches), 32'h00);
        chk("async rst o_Events", 32'(o_Events), 32'h00);
        chk("async rst o_Changed", 32'(o_Changed), 32'h0);
        clocks(2);
        rst_n = 1'b1;
        wait_sw(8'hFF, 8'hA5, 30, n);
        chk("post-rst o_Switches", 32'(o_Switches), 32'hA5);
        chk("post-rst latency <= 14", 32'(n <= 14), 32'h1);
        chk("post-rst o_Events", 32'(o_Events), 32'hA5);

`ifdef E2LP_SWITCH_IRQ_EN
        // 6) masked interrupt
        irq_mask_v = 8'h80;
        pulse_get();
        SWITCHES = 8'hA4;
        wait_sw(8'h01, 8'h00, 30, n);
        chk("irq unmasked bit event", 32'(o_Events), 32'h01);
        chk("irq stays low", 32'(irq_w), 32'h0);
        SWITCHES = 8'h24;
        wait_sw(8'h80, 8'h00, 30, n);
        chk("irq o_Events[7]", 32'(o_Events[7]), 32'h1);
        chk("irq high", 32'(irq_w), 32'h1);
        pulse_get();
        chk("irq cleared", 32'(irq_w), 32'h0);
`endif

        // Randomized bouncing pins, random Get and mask
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (hold == 0) begin
                SWITCHES = SWITCHES ^ 8'($urandom_range(0, 255) & $urandom_range(0, 255));
                hold = $urandom_range(1, 20);
            end else begin
                hold--;
            end
            Get = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) == 0) irq_mask_v = 8'($urandom_range(0, 255));
        end
        Get = 1'b0;
        clocks(2);
        cmp_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
